// File: rtl/ppi_host.sv
// Bus-side initiator for an 8255-style PPI: buffers read/write commands in a FIFO and
// replays them on the PPI bus with programmable setup / strobe / hold timing.
module ppi_host #(
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [1:0] ppi_addr,
    output logic [7:0] ppi_idata,
    output logic       ppi_we_n,
    input  logic [7:0] ppi_odata
);

    localparam int PW    = $clog2(DEPTH);
    localparam int MAX_T = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                           : ((PULSE > HOLD) ? PULSE : HOLD);
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_SAMPLE} state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop, sample, op_we;
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (count != '0) || (state != ST_IDLE);

    // NOTE: storage array has no reset; only pointers and count are reset, so a flush is just count = 0.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        sample     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ST_SETUP;
                    cnt_next   = CW'(SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_next = op_we ? ST_STROBE : ST_SAMPLE;
                    cnt_next   = op_we ? CW'(PULSE - 1) : '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = CW'(HOLD - 1);
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) state_next = ST_IDLE;
                else           cnt_next   = cnt - 1'b1;
            end
            ST_SAMPLE: begin
                sample     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Strobe is registered from the next state so it switches cleanly on the state edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ppi_we_n  <= 1'b1;
            ppi_addr  <= '0;
            ppi_idata <= '0;
            op_we     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            ppi_we_n  <= (state_next != ST_STROBE);
            rsp_valid <= sample;
            if (sample)
                rsp_data <= ppi_odata;
            if (pop) begin
                ppi_addr <= head.addr;
                op_we    <= head.we;
                if (head.we)
                    ppi_idata <= head.wdata;
            end
        end
    end

endmodule

// File: tb/tb_ppi_host.sv
// Self-checking bench for ppi_host: default-timing instance plus a long-strobe instance
// for FIFO back-pressure, with a scoreboard of expected PPI writes and read responses.
module tb_ppi_host;

    localparam int SETUP_T    = 1;
    localparam int PULSE_T    = 2;
    localparam int HOLD_T     = 1;
    localparam int PULSE_SLOW = 8;
    localparam int OCC        = 1 + SETUP_T + PULSE_T + HOLD_T;
    localparam int OCC_SLOW   = 1 + SETUP_T + PULSE_SLOW + HOLD_T;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_we;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       cmd_valid_m, cmd_ready_m, rsp_valid_m, busy_m, ppi_we_n_m;
    logic [7:0] rsp_data_m, ppi_idata_m, ppi_odata_m;
    logic [1:0] ppi_addr_m;
    logic       cmd_valid_s, cmd_ready_s, rsp_valid_s, busy_s, ppi_we_n_s;
    logic [7:0] rsp_data_s, ppi_idata_s, ppi_odata_s;
    logic [1:0] ppi_addr_s;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [9:0] exp_wr_m [$];
    logic [9:0] exp_wr_s [$];
    logic [7:0] exp_rsp_m [$];
    int         fall_cyc_m [$];
    int         rsp_cyc_m = -1;
    int         strobe_cnt_m = 0, strobe_cnt_s = 0, rsp_cnt_m = 0;
    logic       prev_we_m = 1'b1, prev_we_s = 1'b1;
    logic [7:0] ppi_regs [4];
    logic [7:0] rd_val [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ppi_odata_m = rd_val[ppi_addr_m];
    assign ppi_odata_s = rd_val[ppi_addr_s];

    ppi_host #(.SETUP(SETUP_T), .PULSE(PULSE_T), .HOLD(HOLD_T), .DEPTH(4)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_m), .cmd_ready(cmd_ready_m), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_m), .rsp_data(rsp_data_m), .busy(busy_m),
        .ppi_addr(ppi_addr_m), .ppi_idata(ppi_idata_m), .ppi_we_n(ppi_we_n_m),
        .ppi_odata(ppi_odata_m)
    );

    ppi_host #(.SETUP(SETUP_T), .PULSE(PULSE_SLOW), .HOLD(HOLD_T), .DEPTH(4)) u_slow (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_s), .rsp_data(rsp_data_s), .busy(busy_s),
        .ppi_addr(ppi_addr_s), .ppi_idata(ppi_idata_s), .ppi_we_n(ppi_we_n_s),
        .ppi_odata(ppi_odata_s)
    );

    // Scoreboard monitors: a falling strobe is the PPI write latch; rsp_valid is a read response.
    always @(negedge clk) begin
        logic [9:0] ew;
        logic [7:0] er;
        if (!reset) begin
            if (prev_we_m && !ppi_we_n_m) begin
                strobe_cnt_m++;
                fall_cyc_m.push_back(cyc);
                ppi_regs[ppi_addr_m] = ppi_idata_m;
                checks++;
                if (exp_wr_m.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr=%0d data=%02h, none expected", ppi_addr_m, ppi_idata_m);
                end else begin
                    ew = exp_wr_m.pop_front();
                    if ({ppi_addr_m, ppi_idata_m} !== ew) begin
                        errors++;
                        $display("FAIL wr_order: got addr=%0d data=%02h want addr=%0d data=%02h",
                                 ppi_addr_m, ppi_idata_m, ew[9:8], ew[7:0]);
                    end
                end
            end
            if (rsp_valid_m) begin
                rsp_cnt_m++;
                rsp_cyc_m = cyc;
                checks++;
                if (exp_rsp_m.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got data=%02h, none expected", rsp_data_m);
                end else begin
                    er = exp_rsp_m.pop_front();
                    if (rsp_data_m !== er) begin
                        errors++;
                        $display("FAIL rsp_data: got %02h want %02h", rsp_data_m, er);
                    end
                end
            end
            if (prev_we_s && !ppi_we_n_s) begin
                strobe_cnt_s++;
                checks++;
                if (exp_wr_s.size() == 0) begin
                    errors++;
                    $display("FAIL slow_wr_unexpected: got addr=%0d data=%02h", ppi_addr_s, ppi_idata_s);
                end else begin
                    ew = exp_wr_s.pop_front();
                    if ({ppi_addr_s, ppi_idata_s} !== ew) begin
                        errors++;
                        $display("FAIL slow_wr_order: got addr=%0d data=%02h want addr=%0d data=%02h",
                                 ppi_addr_s, ppi_idata_s, ew[9:8], ew[7:0]);
                    end
                end
            end
            if (rsp_valid_s) begin
                errors++;
                checks++;
                $display("FAIL slow_rsp_unexpected: got data=%02h, no reads issued", rsp_data_s);
            end
        end
        prev_we_m = ppi_we_n_m;
        prev_we_s = ppi_we_n_s;
    end

    // Called at #1 after a clock edge; returns at #1 after the accepting edge.
    task automatic push(input bit slow, input bit we, input logic [1:0] addr, input logic [7:0] data);
        int waited = 0;
        while ((slow ? cmd_ready_s : cmd_ready_m) !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (waited >= 100) begin
            errors++;
            $display("FAIL push_timeout: cmd_ready got 0 for 100 cycles want 1");
        end
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = data;
        if (slow) cmd_valid_s = 1'b1;
        else      cmd_valid_m = 1'b1;
        if (we && slow)  exp_wr_s.push_back({addr, data});
        if (we && !slow) exp_wr_m.push_back({addr, data});
        if (!we)         exp_rsp_m.push_back(rd_val[addr]);
        @(posedge clk); #1;
        cmd_valid_m = 1'b0;
        cmd_valid_s = 1'b0;
    endtask

    task automatic wait_idle(input bit slow, input int budget, input string name);
        int waited = 0;
        while ((slow ? busy_s : busy_m) !== 1'b0 && waited < budget) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (waited >= budget) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy got 1 after %0d cycles want 0", name, budget);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (ppi_we_n_m !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b want 1", ppi_we_n_m); end
        checks++; if (ppi_addr_m !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", ppi_addr_m); end
        checks++; if (ppi_idata_m !== 8'h00) begin errors++; $display("FAIL reset_idata: got %02h want 00", ppi_idata_m); end
        checks++; if (rsp_valid_m !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_m); end
        checks++; if (rsp_data_m !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %02h want 00", rsp_data_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_m); end
        checks++; if (cmd_ready_m !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready_m); end
        checks++; if (cmd_ready_s !== 1'b1) begin errors++; $display("FAIL reset_ready_slow: got %b want 1", cmd_ready_s); end
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (cmd_ready_m !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready_m); end
    endtask

    task automatic test_single_write();
        push(1'b0, 1'b1, 2'd0, 8'h5A);
        for (int k = 1; k <= 6; k++) begin
            bit exp_low;
            @(posedge clk); #1;
            exp_low = (k >= 1 + SETUP_T) && (k <= SETUP_T + PULSE_T);
            checks++;
            if (ppi_we_n_m !== !exp_low) begin
                errors++; $display("FAIL wr_we_n_k%0d: got %b want %b", k, ppi_we_n_m, !exp_low);
            end
            if (k <= SETUP_T + PULSE_T + HOLD_T) begin
                checks++;
                if (ppi_addr_m !== 2'd0 || ppi_idata_m !== 8'h5A) begin
                    errors++; $display("FAIL wr_bus_k%0d: got %0d/%02h want 0/5a", k, ppi_addr_m, ppi_idata_m);
                end
            end
            checks++;
            if (rsp_valid_m !== 1'b0) begin errors++; $display("FAIL wr_no_rsp_k%0d: got %b want 0", k, rsp_valid_m); end
            if (k == 1) begin
                checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy_m); end
            end
            if (k == OCC) begin
                checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL wr_busy_fall: got %b want 0", busy_m); end
            end
        end
        checks++;
        if (exp_wr_m.size() != 0) begin errors++; $display("FAIL wr_pending: got %0d left want 0", exp_wr_m.size()); end
    endtask

    task automatic test_single_read();
        rd_val[1] = 8'hC3;
        push(1'b0, 1'b0, 2'd1, 8'hEE);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ppi_we_n_m !== 1'b1) begin errors++; $display("FAIL rd_we_n_k%0d: got %b want 1", k, ppi_we_n_m); end
            checks++;
            if (rsp_valid_m !== (k == 2 + SETUP_T)) begin
                errors++; $display("FAIL rd_rsp_valid_k%0d: got %b want %b", k, rsp_valid_m, (k == 2 + SETUP_T));
            end
            if (k >= 2 + SETUP_T) begin
                checks++;
                if (rsp_data_m !== 8'hC3) begin errors++; $display("FAIL rd_rsp_hold_k%0d: got %02h want c3", k, rsp_data_m); end
            end
            if (k == 1) begin
                checks++;
                if (ppi_addr_m !== 2'd1 || ppi_idata_m !== 8'h5A) begin
                    errors++; $display("FAIL rd_bus: got %0d/%02h want 1/5a", ppi_addr_m, ppi_idata_m);
                end
            end
        end
        checks++;
        if (exp_rsp_m.size() != 0) begin errors++; $display("FAIL rd_pending: got %0d left want 0", exp_rsp_m.size()); end
    endtask

    task automatic test_back_to_back();
        int n0;
        rd_val[1] = 8'h3C;
        fall_cyc_m.delete();
        push(1'b0, 1'b1, 2'd3, 8'h82);
        n0 = cyc;
        push(1'b0, 1'b1, 2'd0, 8'h11);
        push(1'b0, 1'b0, 2'd1, 8'h00);
        wait_idle(1'b0, 60, "b2b");
        checks++;
        if (fall_cyc_m.size() != 2) begin
            errors++; $display("FAIL b2b_strobes: got %0d want 2", fall_cyc_m.size());
        end else begin
            checks++;
            if (fall_cyc_m[0] != n0 + 1 + SETUP_T) begin
                errors++; $display("FAIL b2b_first_fall: got %0d want %0d", fall_cyc_m[0], n0 + 1 + SETUP_T);
            end
            checks++;
            if (fall_cyc_m[1] != fall_cyc_m[0] + OCC) begin
                errors++; $display("FAIL b2b_spacing: got %0d want %0d", fall_cyc_m[1] - fall_cyc_m[0], OCC);
            end
        end
        checks++;
        if (rsp_cyc_m != n0 + 1 + 2 * OCC + SETUP_T + 1) begin
            errors++; $display("FAIL b2b_rsp_time: got %0d want %0d", rsp_cyc_m, n0 + 1 + 2 * OCC + SETUP_T + 1);
        end
        checks++;
        if (ppi_regs[3] !== 8'h82 || ppi_regs[0] !== 8'h11) begin
            errors++; $display("FAIL b2b_model: got ctl=%02h a=%02h want 82/11", ppi_regs[3], ppi_regs[0]);
        end
        checks++;
        if (exp_wr_m.size() != 0 || exp_rsp_m.size() != 0) begin
            errors++; $display("FAIL b2b_pending: got wr=%0d rsp=%0d want 0/0", exp_wr_m.size(), exp_rsp_m.size());
        end
    endtask

    task automatic test_fifo_full();
        int n0 = 0;
        int waited = 0;
        int sc0 = strobe_cnt_s;
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 1'b1, 2'(i), 8'hA0 + 8'(i));
            if (i == 0) n0 = cyc;
        end
        checks++;
        if (cmd_ready_s !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", cmd_ready_s); end
        while (cmd_ready_s !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (cyc != n0 + 1 + OCC_SLOW) begin
            errors++; $display("FAIL full_ready_recover: got cycle %0d want %0d", cyc, n0 + 1 + OCC_SLOW);
        end
        push(1'b1, 1'b1, 2'd1, 8'hA5);
        wait_idle(1'b1, 200, "full");
        checks++;
        if (strobe_cnt_s - sc0 != 6) begin
            errors++; $display("FAIL full_count: got %0d strobes want 6", strobe_cnt_s - sc0);
        end
        checks++;
        if (exp_wr_s.size() != 0) begin errors++; $display("FAIL full_pending: got %0d left want 0", exp_wr_s.size()); end
    endtask

    task automatic test_reset_strobe();
        int waited = 0;
        int sc, rc;
        push(1'b0, 1'b1, 2'd2, 8'h21);
        push(1'b0, 1'b1, 2'd2, 8'h22);
        push(1'b0, 1'b1, 2'd2, 8'h23);
        while (ppi_we_n_m !== 1'b0 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (ppi_we_n_m !== 1'b0) begin errors++; $display("FAIL rst_strobe_seen: got %b want 0", ppi_we_n_m); end
        checks++;
        if (busy_m !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b want 1", busy_m); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ppi_we_n_m !== 1'b1) begin errors++; $display("FAIL rst_we_n: got %b want 1", ppi_we_n_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_m); end
        checks++; if (cmd_ready_m !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready_m); end
        checks++;
        if (ppi_addr_m !== 2'd0 || ppi_idata_m !== 8'h00) begin
            errors++; $display("FAIL rst_bus: got %0d/%02h want 0/00", ppi_addr_m, ppi_idata_m);
        end
        exp_wr_m.delete();
        exp_rsp_m.delete();
        sc = strobe_cnt_m;
        rc = rsp_cnt_m;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (strobe_cnt_m != sc || rsp_cnt_m != rc) begin
            errors++; $display("FAIL rst_no_activity: got %0d strobes %0d rsps want 0/0", strobe_cnt_m - sc, rsp_cnt_m - rc);
        end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b want 0", busy_m); end
        checks++; if (ppi_we_n_m !== 1'b1) begin errors++; $display("FAIL rst_we_n_after: got %b want 1", ppi_we_n_m); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid_m = 1'b0;
        cmd_valid_s = 1'b0;
        cmd_we      = 1'b0;
        cmd_addr    = 2'd0;
        cmd_wdata   = 8'h00;
        for (int i = 0; i < 4; i++) begin
            ppi_regs[i] = 8'h00;
            rd_val[i]   = 8'h10 + 8'(i);
        end
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_fifo_full();
        test_reset_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
